// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
// Frame format: start bit, LSB-first data, parity bit, stop bit.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  // High when the data parity plus the received parity bit disagree with the selected sense.
  function automatic logic parity_mismatch(input logic acc, input logic par_bit, input logic odd);
    return acc ^ par_bit ^ odd;
  endfunction

endpackage

// File: rtl/serial_frame_rx.sv
// Receives start/data/parity/stop frames from a gated serial stream and
// presents each good word on a registered parallel output with status pulses.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              serialIn,
  input  logic              bitEnable,
  output logic [DATA_W-1:0] dataOut,
  output logic              dataValid,
  output logic              parityError,
  output logic              frameError,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic                mism_q, mism_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                busy_q, busy_d;

  // Next-state and datapath; nothing advances on a stalled edge, pulses default low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    mism_d  = mism_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    if (bitEnable) begin
      case (state_q)
        IDLE: begin
          if (serialIn == START_BIT) begin
            state_d = DATA;
            cnt_d   = '0;
            par_d   = 1'b0;
            mism_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          shift_d[cnt_q] = serialIn;
          par_d          = par_q ^ serialIn;
          if (cnt_q == CNT_LAST) begin
            state_d = PARITY;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        PARITY: begin
          mism_d  = parity_mismatch(par_q, serialIn, PARITY_ODD);
          state_d = STOP;
        end
        STOP: begin
          if (serialIn == STOP_BIT) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            perr_d  = mism_q;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      mism_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      mism_q  <= mism_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign dataOut     = data_q;
  assign dataValid   = valid_q;
  assign parityError = perr_q;
  assign frameError  = ferr_q;
  assign busy        = busy_q;

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Downstream consumer of the 2-bit shift register's serialOutput stream.
- Frames the bit stream as: start bit (1), DATA_W data bits LSB-first, parity bit, stop bit (0).
- Reassembles each frame into a parallel word and flags parity and framing errors.
- Sits between the shift-register stage and any word-level logic. Samples one bit per clk edge when bitEnable is high.

Parameters:
- DATA_W, 8, number of data bits per frame (2..16).
- PARITY_ODD, 0, 0 = even parity (data bits plus parity bit hold an even number of 1s), 1 = odd parity.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clr  input  1  synchronous, active-high reset.
- serialIn  input  1  serial bit from upstream serialOutput.
- bitEnable  input  1  high when serialIn holds a valid bit this cycle; low stalls the receiver.
- dataOut  output  DATA_W  last successfully received word.
- dataValid  output  1  one-cycle pulse when a new word is loaded into dataOut.
- parityError  output  1  one-cycle pulse, coincident with dataValid, when parity mismatched.
- frameError  output  1  one-cycle pulse when the stop bit sampled as 1.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset: clr sampled high at a rising edge forces the following, overriding every other input that cycle:
  - state = IDLE, bit counter = 0, shift accumulator = 0, parity accumulator = 0.
  - dataOut = 0; dataValid, parityError, frameError, busy = 0.
- Stall rule: no state, counter or accumulator advances on any edge where bitEnable = 0. Pulse outputs still deassert on such edges.
- FSM, evaluated only on edges where bitEnable = 1:
  - IDLE: serialIn = 1 -> DATA, counter = 0, parity accumulator = 0. serialIn = 0 -> stay in IDLE (idle line).
  - DATA: shift serialIn into the accumulator at bit index = counter (LSB first) and XOR it into the parity accumulator. When counter = DATA_W-1 -> PARITY, otherwise counter + 1.
  - PARITY: capture the parity bit. Mismatch is parity accumulator XOR serialIn XOR PARITY_ODD != 0. -> STOP.
  - STOP, serialIn = 0: load dataOut from the accumulator, pulse dataValid, pulse parityError if a mismatch was captured. -> IDLE.
  - STOP, serialIn = 1: pulse frameError, leave dataOut unchanged, no dataValid, no parityError. -> IDLE.
- Output timing:
  - All outputs are registered.
  - dataValid, parityError and frameError are high for exactly the one cycle after the edge that sampled the stop bit.
  - Latency from the start-bit edge to dataValid high = DATA_W+3 enabled edges.
- Back-to-back frames: a start bit may arrive on the enabled edge immediately after STOP. IDLE evaluates it normally, with no dead cycle beyond the STOP->IDLE transition.
- Error recovery: after frameError the FSM resynchronises on the next 1 seen while in IDLE.
- Reset mid-frame: the partial frame is discarded, no pulse is emitted, and dataOut is cleared to 0.
- Counter width is $clog2(DATA_W); the counter never wraps past DATA_W-1.

Decomposition:
- Package serial_frame_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP), 2-bit encoding;
  - constants START_BIT = 1 and STOP_BIT = 0.
- No sub-module: the shift/parity datapath is small enough to live inline beside the FSM.

Test Plan:
1. Reset: clr = 1 for 2 cycles mid-frame (after 3 data bits) -> all outputs 0, busy = 0. A following clean frame of 0x3C then receives correctly.
2. Good frame, 0xA5 even parity, bitEnable held 1:
   - bits 1, 1,0,1,0,0,1,0,1, 0, 0 -> dataOut = 0xA5.
   - dataValid = 1 for exactly 1 cycle, 11 edges after the start bit; parityError = 0.
3. Parity error: same frame with parity bit 1 -> dataOut = 0xA5, dataValid = 1 and parityError = 1 in the same cycle.
4. Frame error: 0x0F frame with stop bit 1 -> frameError pulse, dataValid = 0, dataOut keeps its previous value (0xA5).
5. Stall: 0x81 frame with bitEnable toggling 1,0,1,0 every cycle and serialIn changed only while enabled -> dataOut = 0x81. dataValid arrives after 11 enabled edges; busy stays 1 throughout the frame.
6. Back-to-back: 0x12 then 0xFE with no idle bits between them -> two dataValid pulses exactly 11 cycles apart, with correct values and no errors.
